// File: rtl/rf_wport_ctrl.sv
// Purpose : shares the single register-file write port between requester A (core
//           writeback) and requester B (load-return / SoC test). It also sequences
//           a hardware clear of x1..x(2^AW-1), because the file itself has no reset.
// Latency : one cycle. A transfer accepted at edge N is driven on rfwr/rfrd/rfD
//           during cycle N+1.
// Backpressure: valid/ready per requester. The readies are combinational in IDLE.
//           A has priority unless B has been denied STARVE consecutive cycles.
//           Both readies are low during a clear sweep and while reset is asserted.
//
// Ports:
//   clk, rst               clock and asynchronous active-low reset
//   clr_start / clr_busy   clear-sweep request (sampled in IDLE) and sweep-running flag
//   a_valid/a_ready/a_rd/a_d   requester A handshake, index and data
//   b_valid/b_ready/b_rd/b_d   requester B handshake, index and data
//   rfwr/rfrd/rfD          registered write enable, index and data to the register file
module rf_wport_ctrl #(
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int STARVE = 4    // legal range 1..15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_d,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_d,
  output logic          rfwr,
  output logic [AW-1:0] rfrd,
  output logic [DW-1:0] rfD
);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [AW-1:0] FIRST_IDX = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_IDX  = {AW{1'b1}};
  localparam logic [3:0]    STARVE_C  = 4'(STARVE);

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_cnt;
  logic          r_rfwr;
  logic [AW-1:0] r_rfrd;
  logic [DW-1:0] r_rfD;

  logic          w_idle;
  logic          w_starved;
  logic          w_a_ready;
  logic          w_b_ready;
  logic          w_a_xfer;
  logic          w_b_xfer;
  logic [AW-1:0] w_sel_rd;
  logic [DW-1:0] w_sel_d;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_starved = (r_cnt == STARVE_C);

  // rst is folded in so the readies read 0 while reset is held, even though the
  // state register already sits at IDLE. A pending clr_start blocks both requesters.
  assign w_a_ready = rst & w_idle & ~clr_start & ~w_starved;
  assign w_b_ready = rst & w_idle & ~clr_start & (w_starved | ~a_valid);

  // The ready terms are mutually exclusive whenever A is valid, so at most one
  // transfer can happen per cycle.
  assign w_a_xfer = a_valid & w_a_ready;
  assign w_b_xfer = b_valid & w_b_ready;
  assign w_sel_rd = w_b_xfer ? b_rd : a_rd;
  assign w_sel_d  = w_b_xfer ? b_d  : a_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= FIRST_IDX;
      r_cnt   <= 4'd0;
      r_rfwr  <= 1'b0;
      r_rfrd  <= '0;
      r_rfD   <= '0;
    end else if (r_state == ST_CLEAR) begin
      // Sweep: one zero write per edge. The starve counter is frozen here.
      r_rfwr <= 1'b1;
      r_rfrd <= r_idx;
      r_rfD  <= '0;
      if (r_idx == LAST_IDX) begin
        r_state <= ST_IDLE;
        r_idx   <= FIRST_IDX;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end else begin
      // A write to x0 completes its handshake but never asserts the write enable.
      if (w_a_xfer || w_b_xfer) begin
        r_rfwr <= (w_sel_rd != '0);
        r_rfrd <= w_sel_rd;
        r_rfD  <= w_sel_d;
      end else begin
        r_rfwr <= 1'b0;
      end

      // Count consecutive denied B cycles and saturate at STARVE.
      if (!b_valid || w_b_xfer) begin
        r_cnt <= 4'd0;
      end else if (!w_starved) begin
        r_cnt <= r_cnt + 4'd1;
      end

      if (clr_start) begin
        r_state <= ST_CLEAR;
        r_idx   <= FIRST_IDX;
      end
    end
  end

  assign clr_busy = (r_state == ST_CLEAR);
  assign a_ready  = w_a_ready;
  assign b_ready  = w_b_ready;
  assign rfwr     = r_rfwr;
  assign rfrd     = r_rfrd;
  assign rfD      = r_rfD;

endmodule

// File: tb/tb_rf_wport_ctrl.sv
module tb_rf_wport_ctrl;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int STARVE = 4;
  localparam int NREGS  = 1 << AW;

  logic          clk;
  logic          rst;
  logic          clr_start;
  logic          clr_busy;
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_rd;
  logic [DW-1:0] a_d;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_rd;
  logic [DW-1:0] b_d;
  logic          rfwr;
  logic [AW-1:0] rfrd;
  logic [DW-1:0] rfD;

  int n_tests;
  int n_fail;

  rf_wport_ctrl #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_d       (a_d),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_d       (b_d),
    .rfwr      (rfwr),
    .rfrd      (rfrd),
    .rfD       (rfD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Table record: inputs for one cycle, expected readies in that cycle and the
  // expected write-port outputs in the following cycle.
  typedef struct {
    logic          clr;
    logic          av;
    logic [AW-1:0] ard;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] brd;
    logic [DW-1:0] bd;
    logic          e_ar;
    logic          e_br;
    logic          e_wr;
    logic [AW-1:0] e_rd;
    logic [DW-1:0] e_d;
    logic          chk_dat;
  } vec_t;

  vec_t vec[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Advance across one rising edge and settle at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clr_start = 1'b0;
    a_valid   = 1'b0;
    a_rd      = '0;
    a_d       = '0;
    b_valid   = 1'b0;
    b_rd      = '0;
    b_d       = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rst_rfwr", 32'(rfwr), 32'd0);
    chk("rst_rfrd", 32'(rfrd), 32'd0);
    chk("rst_rfD", rfD, 32'd0);
    chk("rst_busy", 32'(clr_busy), 32'd0);
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  // Reference model state for the random phase.
  int            m_sweep[$];   // indices still to be cleared
  int            m_deny;       // consecutive denied B cycles, capped at STARVE
  logic          m_wr;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_d;

  initial begin
    logic ar, br, axf, bxf, busy;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    idle_inputs();

    do_reset();

    // ---------------- Sweep after power-up ----------------
    @(negedge clk);
    clr_start = 1'b1;
    #1;
    chk("sw_start_a_ready", 32'(a_ready), 32'd0);
    chk("sw_start_b_ready", 32'(b_ready), 32'd0);
    tick();
    clr_start = 1'b0;
    chk("sw_busy_first", 32'(clr_busy), 32'd1);
    chk("sw_no_write_yet", 32'(rfwr), 32'd0);
    for (int i = 1; i < NREGS; i++) begin
      tick();
      chk($sformatf("sw_wr[%0d]", i), 32'(rfwr), 32'd1);
      chk($sformatf("sw_rd[%0d]", i), 32'(rfrd), 32'(i));
      chk($sformatf("sw_d[%0d]", i), rfD, 32'd0);
      chk($sformatf("sw_busy[%0d]", i), 32'(clr_busy), (i < NREGS - 1) ? 32'd1 : 32'd0);
    end
    tick();
    chk("sw_end_rfwr", 32'(rfwr), 32'd0);
    chk("sw_end_busy", 32'(clr_busy), 32'd0);

    // ---------------- Table-driven vectors ----------------
    vec[0]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
    vec[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1};
    vec[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hCAFE0009, 1'b1, 1'b1, 1'b1, 5'd9, 32'hCAFE0009, 1'b1};
    vec[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h00001234, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0};
    vec[4]  = '{1'b0, 1'b1, 5'd3, 32'hA0000001, 1'b1, 5'd7, 32'hB0000007, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA0000001, 1'b1};
    vec[5]  = '{1'b0, 1'b1, 5'd3, 32'hA0000002, 1'b1, 5'd7, 32'hB0000007, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA0000002, 1'b1};
    vec[6]  = '{1'b0, 1'b1, 5'd3, 32'hA0000003, 1'b1, 5'd7, 32'hB0000007, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA0000003, 1'b1};
    vec[7]  = '{1'b0, 1'b1, 5'd3, 32'hA0000004, 1'b1, 5'd7, 32'hB0000007, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA0000004, 1'b1};
    vec[8]  = '{1'b0, 1'b1, 5'd3, 32'hA0000005, 1'b1, 5'd7, 32'hB0000007, 1'b0, 1'b1, 1'b1, 5'd7, 32'hB0000007, 1'b1};
    vec[9]  = '{1'b0, 1'b1, 5'd3, 32'hA0000005, 1'b1, 5'd7, 32'hB0000008, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA0000005, 1'b1};
    vec[10] = '{1'b0, 1'b1, 5'd3, 32'hA0000006, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd3, 32'hA0000006, 1'b1};
    vec[11] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd3, 32'hA0000006, 1'b1};

    for (int v = 0; v < 12; v++) begin
      clr_start = vec[v].clr;
      a_valid   = vec[v].av;
      a_rd      = vec[v].ard;
      a_d       = vec[v].ad;
      b_valid   = vec[v].bv;
      b_rd      = vec[v].brd;
      b_d       = vec[v].bd;
      #1;
      chk($sformatf("vec%0d_a_ready", v), 32'(a_ready), 32'(vec[v].e_ar));
      chk($sformatf("vec%0d_b_ready", v), 32'(b_ready), 32'(vec[v].e_br));
      tick();
      chk($sformatf("vec%0d_rfwr", v), 32'(rfwr), 32'(vec[v].e_wr));
      if (vec[v].chk_dat) begin
        chk($sformatf("vec%0d_rfrd", v), 32'(rfrd), 32'(vec[v].e_rd));
        chk($sformatf("vec%0d_rfD", v), rfD, vec[v].e_d);
      end
    end
    idle_inputs();

    // ---------------- clr_start together with a held A request ----------------
    clr_start = 1'b1;
    a_valid   = 1'b1;
    a_rd      = 5'd12;
    a_d       = 32'hA5A50012;
    #1;
    chk("cs_a_ready_at_start", 32'(a_ready), 32'd0);
    tick();
    clr_start = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      #1;
      if (a_ready !== 1'b0) chk($sformatf("cs_a_ready_in_sweep[%0d]", i), 32'(a_ready), 32'd0);
      tick();
      if (rfwr !== 1'b1 || rfrd !== AW'(i))
        chk($sformatf("cs_sweep_rd[%0d]", i), 32'(rfrd), 32'(i));
    end
    chk("cs_sweep_last_rd", 32'(rfrd), 32'(NREGS - 1));
    chk("cs_busy_after", 32'(clr_busy), 32'd0);
    chk("cs_a_ready_after", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    chk("cs_a_wr", 32'(rfwr), 32'd1);
    chk("cs_a_rd", 32'(rfrd), 32'd12);
    chk("cs_a_d", rfD, 32'hA5A50012);
    tick();
    chk("cs_idle_after", 32'(rfwr), 32'd0);

    // ---------------- Reset in the middle of a sweep ----------------
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    a_valid   = 1'b1;
    a_rd      = 5'd4;
    a_d       = 32'h00000044;
    b_valid   = 1'b1;
    b_rd      = 5'd6;
    b_d       = 32'h00000066;
    for (int i = 1; i <= 10; i++) tick();
    chk("mr_tenth_rd", 32'(rfrd), 32'd10);
    chk("mr_tenth_wr", 32'(rfwr), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_rfwr", 32'(rfwr), 32'd0);
    chk("mr_busy", 32'(clr_busy), 32'd0);
    chk("mr_a_ready", 32'(a_ready), 32'd0);
    chk("mr_b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_post_busy", 32'(clr_busy), 32'd0);
    chk("mr_post_a_ready", 32'(a_ready), 32'd1);
    tick();
    chk("mr_post_wr", 32'(rfwr), 32'd1);
    chk("mr_post_rd", 32'(rfrd), 32'd4);
    chk("mr_post_d", rfD, 32'h00000044);
    idle_inputs();

    // ---------------- Random stimulus against the reference model ----------------
    do_reset();
    m_sweep.delete();
    m_deny = 0;
    m_wr   = 1'b0;
    m_rd   = '0;
    m_d    = '0;
    @(negedge clk);
    for (int c = 0; c < 800; c++) begin
      // Requesters only change their request once it has been accepted.
      clr_start = ($urandom_range(0, 49) == 0);
      #1;
      busy = (m_sweep.size() != 0);
      if (busy || clr_start) begin
        ar = 1'b0;
        br = 1'b0;
      end else begin
        ar = (m_deny != STARVE);
        br = (m_deny == STARVE) || !a_valid;
      end
      if (a_ready !== ar) chk($sformatf("rnd%0d_a_ready", c), 32'(a_ready), 32'(ar));
      if (b_ready !== br) chk($sformatf("rnd%0d_b_ready", c), 32'(b_ready), 32'(br));
      if (clr_busy !== busy) chk($sformatf("rnd%0d_busy", c), 32'(clr_busy), 32'(busy));
      axf = a_valid && ar;
      bxf = b_valid && br;
      if (busy) begin
        m_wr = 1'b1;
        m_rd = AW'(m_sweep.pop_front());
        m_d  = '0;
      end else begin
        if (axf) begin
          m_wr = (a_rd != 0);
          m_rd = a_rd;
          m_d  = a_d;
        end else if (bxf) begin
          m_wr = (b_rd != 0);
          m_rd = b_rd;
          m_d  = b_d;
        end else begin
          m_wr = 1'b0;
        end
        if (!b_valid || bxf) m_deny = 0;
        else if (m_deny < STARVE) m_deny++;
        if (clr_start) for (int k = 1; k < NREGS; k++) m_sweep.push_back(k);
      end
      tick();
      chk($sformatf("rnd%0d_rfwr", c), 32'(rfwr), 32'(m_wr));
      if (m_wr) begin
        if (rfrd !== m_rd) chk($sformatf("rnd%0d_rfrd", c), 32'(rfrd), 32'(m_rd));
        if (rfD !== m_d) chk($sformatf("rnd%0d_rfD", c), rfD, m_d);
      end
      if (!a_valid || axf) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_rd    = AW'($urandom_range(0, NREGS - 1));
        a_d     = $urandom;
      end
      if (!b_valid || bxf) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_rd    = AW'($urandom_range(0, NREGS - 1));
        b_d     = $urandom;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
